branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Sits beside the branch decision logic. The IF stage queries it with the fetch PC to get a predicted direction and target.
- The EX stage feeds back the resolved branch outcome (br from branch decision) to update entries and to flag mispredictions for pipeline flush.
- Also keeps branch and mispredict statistics counters.

Parameters:
ENTRY_BITS, 6, log2 of BTB entry count (64 entries); index = pc[ENTRY_BITS+1:2], tag = pc[31:ENTRY_BITS+2]

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
pc_if  input  32  fetch-stage PC to look up
pred_taken  output  1  prediction for pc_if: taken
pred_target  output  32  predicted target for pc_if (pc_if+4 when not predicted taken)
ex_valid  input  1  EX stage holds a valid, non-bubbled instruction
ex_is_br  input  1  EX instruction is a conditional branch (br_type != NOBRANCH)
ex_pc  input  32  PC of EX instruction
ex_br  input  1  resolved outcome from branch decision
ex_target  input  32  computed branch target
ex_pred_taken  input  1  prediction carried down the pipe for this instruction
ex_pred_target  input  32  predicted target carried down the pipe
mispredict  output  1  EX branch was mispredicted; flush IF/ID
correct_pc  output  32  redirect PC when mispredict=1
br_count  output  32  number of resolved branches
miss_count  output  32  number of mispredictions

Behaviour:
- Storage per entry: valid(1), tag(32-ENTRY_BITS-2), target(32), cnt(2). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational, zero latency:
  - hit = valid[idx] & (tag[idx] == pc_if tag).
  - pred_taken = hit & cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_if+4 (32-bit wrap).
- Resolution is combinational and qualified by upd = ex_valid & ex_is_br:
  - mispredict = upd & ((ex_br != ex_pred_taken) | (ex_br & ex_pred_taken & (ex_target != ex_pred_target))).
  - correct_pc = ex_br ? ex_target : ex_pc+4. It is don't-care when mispredict=0, but must be driven deterministically by the same expression.
- Update is registered, on the rising clk edge when upd=1, indexed by ex_pc:
  - Hit, ex_br=1: cnt saturating increment (11 stays 11); target <= ex_target.
  - Hit, ex_br=0: cnt saturating decrement (00 stays 00); target unchanged.
  - Miss, ex_br=1: allocate (replaces any other tag at that index): valid<=1, tag<=ex_pc tag, target<=ex_target, cnt<=10.
  - Miss, ex_br=0: no allocation, no change.
- Statistics:
  - br_count += 1 on every upd.
  - miss_count += 1 on every upd with mispredict=1.
  - Both wrap modulo 2^32.
- Simultaneous lookup and update of the same index in one cycle: lookup returns the pre-update contents (no bypass). The write is visible from the next cycle.
- upd=0 (bubble, non-branch, or ex_valid=0): no state change of any kind.
- Reset (rst=0, asynchronous, also mid-operation):
  - All valid bits <= 0, all cnt <= 00, br_count <= 0, miss_count <= 0.
  - target and tag arrays need not be cleared.
  - During and immediately after reset: pred_taken=0, pred_target=pc_if+4, mispredict follows its combinational equation.
- Only the valid/cnt arrays need reset. Target/tag may map to distributed RAM without reset.

Test Plan:
- Reset, pc_if=0x0000_0100 -> pred_taken=0, pred_target=0x0000_0104, br_count=0, miss_count=0.
- Update ex_pc=0x100, ex_br=1, ex_target=0x200, ex_pred_taken=0 -> mispredict=1, correct_pc=0x200. Next cycle pc_if=0x100 gives pred_taken=1, pred_target=0x200 (cnt=10); br_count=1, miss_count=1.
- Same branch resolved not-taken twice (first with ex_pred_taken=1) -> cnt 10->01->00. After the first update pred_taken=0. Only the first update raises mispredict; correct_pc=0x104.
- Four taken updates of 0x100 then one not-taken -> cnt saturates at 11, drops to 10; pred_taken stays 1.
- Alias test (ENTRY_BITS=6): entry 0x100 allocated, then taken branch at 0x200 (same index, different tag) -> 0x100 lookup misses (pred_taken=0), 0x200 hits. Not-taken miss at 0x300 -> no allocation.
- Same-cycle lookup and update of 0x100, then assert rst mid-sequence:
  - Same-cycle lookup returns old prediction.
  - After async reset, all lookups are not-taken and both counters read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating counters,
// combinational lookup/resolution, registered update and branch statistics.
module branch_predictor #(
   parameter int unsigned ENTRY_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_is_br,
   input  logic [31:0] ex_pc,
   input  logic        ex_br,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] correct_pc,
   output logic [31:0] br_count,
   output logic [31:0] miss_count
);

   localparam int unsigned ENTRIES = 1 << ENTRY_BITS;
   localparam int unsigned TAG_W   = 32 - ENTRY_BITS - 2;

   logic              valid_q  [ENTRIES];
   logic [1:0]        cnt_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [31:0]       br_count_q, miss_count_q;

   logic [ENTRY_BITS-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0]      if_tag, ex_tag;
   logic                  if_hit, ex_hit, upd;
   logic [1:0]            cnt_nxt;

   assign if_idx = pc_if[ENTRY_BITS+1:2];
   assign if_tag = pc_if[31:ENTRY_BITS+2];
   assign ex_idx = ex_pc[ENTRY_BITS+1:2];
   assign ex_tag = ex_pc[31:ENTRY_BITS+2];

   // Lookup reads stored state only; a same-cycle update is seen next cycle.
   always_comb begin
      if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken  = if_hit && cnt_q[if_idx][1];
      pred_target = pred_taken ? target_q[if_idx] : pc_if + 32'd4;
   end

   always_comb begin
      upd        = ex_valid && ex_is_br;
      mispredict = upd && ((ex_br != ex_pred_taken) ||
                           (ex_br && ex_pred_taken && (ex_target != ex_pred_target)));
      correct_pc = ex_br ? ex_target : ex_pc + 32'd4;
      ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   end

   always_comb begin
      cnt_nxt = cnt_q[ex_idx];
      if (ex_br) begin
         if (cnt_q[ex_idx] != 2'b11) cnt_nxt = cnt_q[ex_idx] + 2'd1;
      end else begin
         if (cnt_q[ex_idx] != 2'b00) cnt_nxt = cnt_q[ex_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= 2'b00;
         end
         br_count_q   <= '0;
         miss_count_q <= '0;
      end else if (upd) begin
         br_count_q <= br_count_q + 32'd1;
         if (mispredict) miss_count_q <= miss_count_q + 32'd1;
         if (ex_hit) begin
            cnt_q[ex_idx] <= cnt_nxt;
         end else if (ex_br) begin
            valid_q[ex_idx] <= 1'b1;
            cnt_q[ex_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target carry no reset so they can live in plain RAM; valid gates them.
   always_ff @(posedge clk) begin
      if (ex_valid && ex_is_br && ex_br) begin
         tag_q[ex_idx]    <= ex_tag;
         target_q[ex_idx] <= ex_target;
      end
   end

   assign br_count   = br_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed plan plus random traffic, scored against a
// behavioural BTB model through an expected-response queue.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_if = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_br = 1'b0, ex_pred_taken = 1'b0;
   logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
   logic        mispredict;
   logic [31:0] correct_pc, br_count, miss_count;

   branch_predictor #(.ENTRY_BITS(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_if          (pc_if),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_is_br       (ex_is_br),
      .ex_pc          (ex_pc),
      .ex_br          (ex_br),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .correct_pc     (correct_pc),
      .br_count       (br_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] target;
      logic        misp;
      logic [31:0] cpc;
      logic [31:0] brc;
      logic [31:0] missc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: 64 sets addressed by word index, tag is the PC above bit 8.
   bit          m_valid [64];
   int          m_cnt   [64];
   int unsigned m_tag   [64];
   logic [31:0] m_target[64];
   logic [31:0] m_brc, m_missc;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / 256;
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 0;
      end
      m_brc   = 0;
      m_missc = 0;
   endfunction

   function automatic bit m_misp(input bit upd, input bit br, input bit pt,
                                 input logic [31:0] tgt, input logic [31:0] ptg);
      if (!upd) return 0;
      if (br != pt) return 1;
      return br && (tgt != ptg);
   endfunction

   function automatic void m_update(input logic [31:0] pc, input bit br,
                                    input logic [31:0] tgt, input bit misp);
      int i;
      i = idx_of(pc);
      m_brc = m_brc + 1;
      if (misp) m_missc = m_missc + 1;
      if (m_hit(pc)) begin
         if (br) begin
            m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            m_target[i] = tgt;
         end else begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
         end
      end else if (br) begin
         m_valid[i]  = 1;
         m_tag[i]    = tag_of(pc);
         m_target[i] = tgt;
         m_cnt[i]    = 2;
      end
   endfunction

   // One cycle: drive inputs after the edge, queue the expected response, then
   // advance the model by the update that the next edge will commit.
   task automatic step(input string nm, input logic [31:0] p, input bit v, input bit isbr,
                       input logic [31:0] epc, input bit br, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptg, input bit rst_v);
      exp_t e;
      bit   upd;
      @(posedge clk);
      #1;
      pc_if = p; ex_valid = v; ex_is_br = isbr; ex_pc = epc; ex_br = br;
      ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
      rst = rst_v;
      if (!rst_v) m_reset();
      upd     = v && isbr;
      e.name  = nm;
      e.taken = m_taken(p);
      e.target = e.taken ? m_target[idx_of(p)] : p + 32'd4;
      e.misp  = m_misp(upd, br, pt, tgt, ptg);
      e.cpc   = br ? tgt : epc + 32'd4;
      e.brc   = m_brc;
      e.missc = m_missc;
      sb.push_back(e);
      if (rst_v && upd) m_update(epc, br, tgt, e.misp);
   endtask

   task automatic idle(input string nm, input logic [31:0] p);
      step(nm, p, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
   endtask

   task automatic resolve(input string nm, input logic [31:0] p, input logic [31:0] epc,
                          input bit br, input logic [31:0] tgt, input bit pt);
      step(nm, p, 1, 1, epc, br, tgt, pt, pt ? tgt : epc + 32'd4, 1);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (pred_taken !== e.taken || pred_target !== e.target || mispredict !== e.misp ||
             correct_pc !== e.cpc || br_count !== e.brc || miss_count !== e.missc) begin
            n_err++;
            $display("FAIL %s: got taken=%0b tgt=%h misp=%0b cpc=%h brc=%0d miss=%0d; want taken=%0b tgt=%h misp=%0b cpc=%h brc=%0d miss=%0d",
                     e.name, pred_taken, pred_target, mispredict, correct_pc, br_count,
                     miss_count, e.taken, e.target, e.misp, e.cpc, e.brc, e.missc);
         end
      end
   end

   initial begin
      logic [31:0] p, epc, tgt, ptg;
      bit          br, pt;
      int          wait_cnt;
      m_reset();
      // Reset state
      step("reset", 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      step("reset_upd_ignored", 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0);
      idle("post_reset", 32'h100);
      // Allocate 0x100 -> 0x200 (same-cycle lookup sees old miss)
      resolve("alloc", 32'h100, 32'h100, 1, 32'h200, 0);
      idle("alloc_hit", 32'h100);
      // Not-taken twice: 10 -> 01 -> 00
      resolve("nt1", 32'h100, 32'h100, 0, 32'h200, 1);
      resolve("nt2", 32'h100, 32'h100, 0, 32'h200, 0);
      idle("nt_after", 32'h100);
      // Four taken then one not-taken: saturate and drop to 10
      for (int i = 0; i < 4; i++) resolve("sat_t", 32'h100, 32'h100, 1, 32'h200, i > 1);
      resolve("sat_nt", 32'h100, 32'h100, 0, 32'h200, 1);
      idle("sat_after", 32'h100);
      // Taken with a wrong predicted target
      step("bad_target", 32'h100, 1, 1, 32'h100, 1, 32'h240, 1, 32'h200, 1);
      idle("new_target", 32'h100);
      // Non-branch and bubble: no change
      step("non_branch", 32'h100, 1, 0, 32'h100, 1, 32'h999, 0, 32'h0, 1);
      step("bubble", 32'h100, 0, 1, 32'h100, 0, 32'h999, 1, 32'h0, 1);
      // Alias at the same index
      resolve("alias_alloc", 32'h200, 32'h200, 1, 32'h380, 0);
      idle("alias_old", 32'h100);
      idle("alias_new", 32'h200);
      resolve("nt_miss", 32'h300, 32'h300, 0, 32'h500, 0);
      idle("nt_miss_after", 32'h300);
      // Same-cycle lookup/update, then async reset mid-run
      resolve("same_cycle", 32'h100, 32'h100, 1, 32'h400, 0);
      idle("same_cycle_after", 32'h100);
      step("async_rst", 32'h100, 1, 1, 32'h100, 1, 32'h400, 0, 32'h104, 0);
      step("in_rst", 32'h200, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      idle("rst_release", 32'h100);
      idle("rst_release2", 32'h200);
      // Random traffic over a few aliasing PCs and wrapping addresses
      for (int n = 0; n < 400; n++) begin
         p   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
         epc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 15) == 0) epc = 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFFC;
         br  = 1'($urandom_range(0, 1));
         tgt = {$urandom_range(0, 7), 2'b00};
         if ($urandom_range(0, 1) == 1) begin
            pt  = m_taken(epc);
            ptg = pt ? m_target[idx_of(epc)] : epc + 32'd4;
         end else begin
            pt  = 1'($urandom_range(0, 1));
            ptg = {$urandom_range(0, 7), 2'b00};
         end
         step("rand", p, $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, epc, br, tgt,
              pt, ptg, $urandom_range(0, 99) != 0);
      end
      idle("final", 32'h100);
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
